// File: rtl/serial_loader.sv
// Streams DATA_SIZE bits from host words, MSB-first, into a serial memory
// shift chain. The memory shifts only while load_mode is high, so gaps between words are safe.
module serial_loader #(
  parameter int DATA_SIZE  = 25,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  serial_data,
  output logic                  load_mode,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(DATA_SIZE + 1);
  localparam int WW = $clog2(WORD_WIDTH + 1);
  localparam int XW = CW + WW;

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         bits_remaining;
  logic [WW-1:0]         word_bits;
  logic [WORD_WIDTH-1:0] shreg;
  logic [XW-1:0]         rem_ext;
  logic [WW-1:0]         take_bits;
  logic [WW-1:0]         shamt;

  // Widened copy so min(WORD_WIDTH, bits_remaining) works whichever counter is wider.
  always_comb begin
    rem_ext   = XW'(bits_remaining);
    take_bits = (rem_ext >= XW'(WORD_WIDTH)) ? WW'(WORD_WIDTH) : rem_ext[WW-1:0];
    shamt     = WW'(WORD_WIDTH) - take_bits;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:      if (start) state_nx = WAIT_WORD;
        WAIT_WORD: if (word_valid) state_nx = SHIFT;
        SHIFT: begin
          if (word_bits <= WW'(1))
            state_nx = (bits_remaining <= CW'(1)) ? DONE : WAIT_WORD;
        end
        DONE:      state_nx = IDLE;
        default:   state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits_remaining <= '0;
      word_bits      <= '0;
      shreg          <= '0;
    end else if (abort) begin
      bits_remaining <= '0;
      word_bits      <= '0;
      shreg          <= '0;
    end else begin
      case (state)
        IDLE: if (start) bits_remaining <= CW'(DATA_SIZE);
        WAIT_WORD: begin
          if (word_valid) begin
            word_bits <= take_bits;
            // Left-align so a partial final word sends only its low bits.
            shreg     <= word_in << shamt;
          end
        end
        SHIFT: begin
          shreg <= shreg << 1;
          if (word_bits != '0)      word_bits      <= word_bits - WW'(1);
          if (bits_remaining != '0) bits_remaining <= bits_remaining - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    word_ready  = (state == WAIT_WORD);
    load_mode   = (state == SHIFT);
    serial_data = load_mode & shreg[WORD_WIDTH-1];
    busy        = (state != IDLE);
    done        = (state == DONE);
  end

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader (DATA_SIZE=5, WORD_WIDTH=4) with a
// behavioural 5-cell shift memory downstream.
module tb_serial_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, word_valid;
  logic [3:0] word_in;
  logic       word_ready, serial_data, load_mode, busy, done;

  int total = 0;
  int bad   = 0;

  serial_loader #(.DATA_SIZE(5), .WORD_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .serial_data(serial_data), .load_mode(load_mode), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Downstream memory model: shifts serial_data in whenever load_mode is high.
  logic [4:0] mem;
  int         lm_cnt, done_cnt;
  logic       mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      mem <= '0; lm_cnt <= 0; done_cnt <= 0;
    end else begin
      if (load_mode) begin
        mem    <= {mem[3:0], serial_data};
        lm_cnt <= lm_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  // Output vector order: {word_ready, load_mode, serial_data, busy, done}
  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_WAIT = 5'b10010;
  localparam logic [4:0] O_SH1  = 5'b01110;
  localparam logic [4:0] O_SH0  = 5'b01010;
  localparam logic [4:0] O_DONE = 5'b00011;

  typedef struct {
    logic       st;
    logic       ab;
    logic       wv;
    logic [3:0] w;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic ab, input logic wv,
                      input logic [3:0] w, input logic [4:0] exp, input string name);
    @(negedge clk);
    start = st; abort = ab; word_valid = wv; word_in = w;
    #1;
    check(name, int'({word_ready, load_mode, serial_data, busy, done}), int'(exp));
  endtask

  task automatic clear_mem();
    mem_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0, 4'h0, O_IDLE, "idle_clear");
    mem_clr = 1'b0;
  endtask

  task automatic check_mem(input string name, input logic [4:0] m,
                           input int lm, input int dn);
    check({name, "_mem"},   int'(mem), int'(m));
    check({name, "_lmcnt"}, lm_cnt, lm);
    check({name, "_done"},  done_cnt, dn);
  endtask

  initial begin
    start = 0; abort = 0; word_valid = 0; word_in = '0; mem_clr = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", int'({word_ready, load_mode, serial_data, busy, done}), 0);
    reset = 1'b1;

    // Full load with word_valid held high (incl. ignored start mid-load), then a partial last word.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, O_IDLE};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'hA, O_WAIT};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'h1, O_SH1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 4'h1, O_SH0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'h1, O_SH1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'h1, O_SH0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'h1, O_WAIT};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'h0, O_SH1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'h0, O_DONE};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'h0, O_IDLE};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'h0, O_IDLE};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 4'hA, O_WAIT};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 4'hE, O_SH1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 4'hE, O_SH0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 4'hE, O_SH1};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 4'hE, O_SH0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 4'hE, O_WAIT};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 4'h0, O_SH0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 4'h0, O_DONE};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 4'h0, O_IDLE};

    clear_mem();
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].st, tbl[i].ab, tbl[i].wv, tbl[i].w, tbl[i].exp, $sformatf("vec%0d", i));
      if (i == 9) begin
        check_mem("full", 5'b10101, 5, 1);
        clear_mem();
      end
      if (i == 19) check_mem("partial", 5'b10100, 5, 1);
    end

    // Gaps: host withholds the second word for 3 cycles.
    clear_mem();
    step(1'b1, 1'b0, 1'b0, 4'h0, O_IDLE, "gap_start");
    step(1'b0, 1'b0, 1'b1, 4'hA, O_WAIT, "gap_acc1");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_SH1,  "gap_b0");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_SH0,  "gap_b1");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_SH1,  "gap_b2");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_SH0,  "gap_b3");
    for (int g = 0; g < 3; g++)
      step(1'b0, 1'b0, 1'b0, 4'h0, O_WAIT, $sformatf("gap_wait%0d", g));
    step(1'b0, 1'b0, 1'b1, 4'h1, O_WAIT, "gap_acc2");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_SH1,  "gap_b4");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_DONE, "gap_done");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_IDLE, "gap_idle");
    check_mem("gap", 5'b10101, 5, 1);

    // Abort after 2 bits.
    clear_mem();
    step(1'b1, 1'b0, 1'b0, 4'h0, O_IDLE, "ab_start");
    step(1'b0, 1'b0, 1'b1, 4'hA, O_WAIT, "ab_acc");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_SH1,  "ab_b0");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_SH0,  "ab_b1");
    step(1'b0, 1'b1, 1'b0, 4'h0, O_SH1,  "ab_b2");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_IDLE, "ab_idle");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_IDLE, "ab_idle2");
    check_mem("abort", 5'b00101, 3, 0);

    // Abort beats start in IDLE and beats word acceptance in WAIT_WORD.
    step(1'b1, 1'b1, 1'b0, 4'h0, O_IDLE, "abst_idle");
    step(1'b1, 1'b0, 1'b0, 4'h0, O_IDLE, "abst_after");
    step(1'b0, 1'b1, 1'b1, 4'hF, O_WAIT, "abacc_wait");
    step(1'b0, 1'b0, 1'b1, 4'hF, O_IDLE, "abacc_after");
    check("abort_nodone", done_cnt, 0);

    // Asynchronous reset mid-SHIFT, then a fresh full load.
    clear_mem();
    step(1'b1, 1'b0, 1'b0, 4'h0, O_IDLE, "rst_start");
    step(1'b0, 1'b0, 1'b1, 4'hA, O_WAIT, "rst_acc");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_SH1,  "rst_b0");
    #2 reset = 1'b0;
    #1;
    check("rst_async", int'({word_ready, load_mode, serial_data, busy, done}), 0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'hA, O_IDLE, "rst_needs_start");
    clear_mem();
    step(1'b1, 1'b0, 1'b0, 4'h0, O_IDLE, "rs_start");
    step(1'b0, 1'b0, 1'b1, 4'hA, O_WAIT, "rs_acc1");
    step(1'b0, 1'b0, 1'b1, 4'h1, O_SH1,  "rs_b0");
    step(1'b0, 1'b0, 1'b1, 4'h1, O_SH0,  "rs_b1");
    step(1'b0, 1'b0, 1'b1, 4'h1, O_SH1,  "rs_b2");
    step(1'b0, 1'b0, 1'b1, 4'h1, O_SH0,  "rs_b3");
    step(1'b0, 1'b0, 1'b1, 4'h1, O_WAIT, "rs_acc2");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_SH1,  "rs_b4");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_DONE, "rs_done");
    step(1'b0, 1'b0, 1'b0, 4'h0, O_IDLE, "rs_idle");
    check_mem("restart", 5'b10101, 5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_loader.md
SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 Parameter DATA_SIZE, default 25: total cells in the system memory shift chain; must be at least 1.
REQ-002 Parameter WORD_WIDTH, default 8: width of each host word; must be at least 1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin loading a full grid; honoured in IDLE only.
REQ-006 abort  input  1  cancels any load in progress.
REQ-007 word_in  input  WORD_WIDTH  host grid word, consumed MSB-first.
REQ-008 word_valid  input  1  word_in holds a valid word.
REQ-009 word_ready  output  1  loader accepts word_in this cycle.
REQ-010 serial_data  output  1  bit presented to system memory serial_in.
REQ-011 load_mode  output  1  drives system memory load_mode; high means memory shifts serial_data in on the next edge.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse when all DATA_SIZE bits have been presented.

Function
REQ-014 The FSM SHALL have four states: IDLE, WAIT_WORD, SHIFT and DONE.
REQ-015 IDLE: on start, the FSM SHALL go to WAIT_WORD and load bits_remaining with DATA_SIZE.
REQ-016 WAIT_WORD: word_ready SHALL be 1, and only in this state.
REQ-017 A word SHALL be accepted when word_valid and word_ready are both 1; the FSM then goes to SHIFT.
REQ-018 On acceptance, word_bits SHALL be set to min(WORD_WIDTH, bits_remaining).
REQ-019 On acceptance, the shift register SHALL be loaded with word_in shifted left by (WORD_WIDTH - word_bits), so a partial final word uses its low word_bits bits.
REQ-020 SHIFT: load_mode SHALL be 1 and serial_data SHALL equal the shift register MSB.
REQ-021 Each SHIFT cycle SHALL shift the register left by one and decrement both word_bits and bits_remaining.
REQ-022 On the last SHIFT cycle of a word, the FSM SHALL go to DONE if bits_remaining becomes 0, otherwise to WAIT_WORD.
REQ-023 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 load_mode SHALL be 0 in IDLE, WAIT_WORD and DONE, so memory never shifts during word gaps.
REQ-025 load_mode SHALL be high for exactly DATA_SIZE cycles per completed load, in bit order MSB-first.
REQ-026 Each accepted word SHALL be followed by at least one WAIT_WORD cycle before the next acceptance (one-bubble throughput).
REQ-027 Words presented with word_valid=1 outside WAIT_WORD SHALL be ignored and held by the host.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 abort in any state SHALL force IDLE on the next edge without asserting done.
REQ-030 abort SHALL take precedence over start and over word acceptance in the same cycle.
REQ-031 Counters SHALL be sized to clog2(DATA_SIZE+1) and clog2(WORD_WIDTH+1) bits and SHALL never underflow.
REQ-032 serial_data SHALL be 0 whenever load_mode is 0.

Reset
REQ-033 On reset low, the following SHALL clear immediately without waiting for clk: the FSM (to IDLE), the counters and the shift register.
REQ-034 During reset, word_ready, serial_data, load_mode, busy and done SHALL all be 0.
REQ-035 Reset asserted mid-load SHALL discard all progress; after release, a fresh start is required.

Verification (DATA_SIZE=5, WORD_WIDTH=4; the bench includes system_memory_v4 downstream)
REQ-036 Full load: start, then words 4'b1010 and 4'b0001 with word_valid held high -> serial_data sequence 1,0,1,0,1 under load_mode; done pulses once; memory reads 5'b10101.
REQ-037 Gaps: insert 3 idle cycles with word_valid=0 between the two words -> load_mode low throughout the gap; memory still ends at 5'b10101.
REQ-038 Partial word: the second word is 4'b1110 -> only bit0 (0) is sent; memory reads 5'b10100; total load_mode-high cycles equal 5.
REQ-039 Abort: abort after 2 bits -> FSM in IDLE next cycle; load_mode=0; no done pulse; busy=0.
REQ-040 Reset mid-SHIFT: drive reset low asynchronously between edges -> all outputs 0 immediately; start after release restarts from bit 0.
REQ-041 Ignored inputs: start asserted while busy, and word_valid high during SHIFT -> no state change and no extra word accepted.
